// File: rtl/ws2812_pkg.sv
// Shared types, default timing and helpers for the WS2812 serializer.
package ws2812_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoaded,
        StShifting,
        StDrain
    } state_e;

    // Defaults for a 12 MHz clock: 1.25 us bit, 0.42 us / 0.83 us high times.
    localparam int unsigned DEF_CYCLES_PER_BIT = 15;
    localparam int unsigned DEF_T0H_CYCLES     = 5;
    localparam int unsigned DEF_T1H_CYCLES     = 10;
    localparam int unsigned DEF_BITS_PER_PIXEL = 24;

    // WS2812 wants green first, then red, then blue.
    function automatic logic [23:0] pack_grb(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Per-bit timing: counts cycles within a bit and produces the high/low level.
module ws2812_bit_encoder #(
    parameter int unsigned CYCLES_PER_BIT = 15,
    parameter int unsigned T0H_CYCLES     = 5,
    parameter int unsigned T1H_CYCLES     = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic enable,
    input  logic bit_value,
    output logic level,
    output logic bit_end
);

    localparam int unsigned CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CYCLE = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] T0H        = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H        = CW'(T1H_CYCLES);

    // bit_cycle_q is the position within the bit that the next clock edge puts on the line.
    // The start edge emits position 0 itself, so the counter resumes at 1.
    logic [CW-1:0] bit_cycle_q, bit_cycle_d;

    // Level and bit-end decode; counter next-state with explicit wrap.
    always_comb begin
        level       = bit_cycle_q < (bit_value ? T1H : T0H);
        bit_end     = (bit_cycle_q == LAST_CYCLE);
        bit_cycle_d = '0;
        if (start) begin
            bit_cycle_d = CW'(1);
        end else if (enable) begin
            bit_cycle_d = bit_end ? '0 : bit_cycle_q + 1'b1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cycle_q <= '0;
        end else begin
            bit_cycle_q <= bit_cycle_d;
        end
    end

endmodule

// File: rtl/ws2812_pixel_serializer.sv
// Serializes one {G,R,B} pixel onto the WS2812 data line and flags protocol errors.
module ws2812_pixel_serializer
    import ws2812_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = DEF_CYCLES_PER_BIT,
    parameter int unsigned T0H_CYCLES     = DEF_T0H_CYCLES,
    parameter int unsigned T1H_CYCLES     = DEF_T1H_CYCLES,
    parameter int unsigned BITS_PER_PIXEL = DEF_BITS_PER_PIXEL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_sreg,
    input  logic       transmit_pixel,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic       err_clr,
    output logic       dout,
    output logic       busy,
    output logic       pixel_done,
    output logic       err_underrun,
    output logic       err_abort
);

    localparam int unsigned SW = BITS_PER_PIXEL;
    localparam int unsigned BW = $clog2(BITS_PER_PIXEL + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_PIXEL - 1);

    state_e        state_q, state_d;
    logic [SW-1:0] sreg_q, sreg_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          dout_q, dout_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;
    logic          abort_q, abort_d;
    logic          underrun_evt, abort_evt;
    logic          enc_start, enc_enable, enc_level, enc_bit_end;

    ws2812_bit_encoder #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT),
        .T0H_CYCLES    (T0H_CYCLES),
        .T1H_CYCLES    (T1H_CYCLES)
    ) u_encoder (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (enc_start),
        .enable   (enc_enable),
        .bit_value(sreg_q[SW-1]),
        .level    (enc_level),
        .bit_end  (enc_bit_end)
    );

    // FSM next state, shift register, bit counter, line level and error events.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = 1'b0;
        done_d       = 1'b0;
        underrun_evt = 1'b0;
        abort_evt    = 1'b0;
        enc_start    = 1'b0;
        enc_enable   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_sreg) begin
                    sreg_d  = SW'(pack_grb(red, green, blue));
                    state_d = StLoaded;
                end else if (transmit_pixel) begin
                    underrun_evt = 1'b1;
                end
            end
            StLoaded: begin
                // A fresh load takes priority over a simultaneous transmit request.
                if (load_sreg) begin
                    sreg_d = SW'(pack_grb(red, green, blue));
                end else if (transmit_pixel) begin
                    state_d   = StShifting;
                    bit_cnt_d = '0;
                    enc_start = 1'b1;
                    dout_d    = enc_level;
                end
            end
            StShifting: begin
                if (!transmit_pixel) begin
                    state_d   = StIdle;
                    sreg_d    = '0;
                    bit_cnt_d = '0;
                    abort_evt = 1'b1;
                end else begin
                    enc_enable = 1'b1;
                    dout_d     = enc_level;
                    if (enc_bit_end) begin
                        sreg_d    = sreg_q << 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            done_d  = 1'b1;
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (!transmit_pixel) begin
                    if (load_sreg) begin
                        sreg_d  = SW'(pack_grb(red, green, blue));
                        state_d = StLoaded;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A new error event in the same cycle as err_clr keeps the flag set.
        underrun_d = underrun_evt | (underrun_q & ~err_clr);
        abort_d    = abort_evt | (abort_q & ~err_clr);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            dout_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            abort_q    <= abort_d;
        end
    end

    assign dout         = dout_q;
    assign busy         = (state_q == StShifting);
    assign pixel_done   = done_q;
    assign err_underrun = underrun_q;
    assign err_abort    = abort_q;

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Randomized bench for the WS2812 serializer against a waveform-level reference model.
module tb_ws2812_pixel_serializer;

    localparam int CPB  = 15;
    localparam int T0H  = 5;
    localparam int T1H  = 10;
    localparam int BPP  = 24;
    localparam int NCYC = CPB * BPP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_sreg = 1'b0;
    logic       transmit_pixel = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] red = '0, green = '0, blue = '0;
    logic       dout, busy, pixel_done, err_underrun, err_abort;

    int checks = 0;
    int errors = 0;

    // Observed line level, indexed by cycles since the transmit edge.
    logic wave [NCYC];
    int   done_cnt, done_pos, busy_bad;

    always #5 clk = ~clk;

    ws2812_pixel_serializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_sreg     (load_sreg),
        .transmit_pixel(transmit_pixel),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .err_clr       (err_clr),
        .dout          (dout),
        .busy          (busy),
        .pixel_done    (pixel_done),
        .err_underrun  (err_underrun),
        .err_abort     (err_abort)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level k cycles into a pixel: bit k/CPB, MSB first, high while within its high time.
    function automatic logic model_level(input logic [23:0] grb, input int k);
        int  b;
        int  pos;
        logic v;
        b   = k / CPB;
        pos = k % CPB;
        v   = grb[BPP - 1 - b];
        return (pos < (v ? T1H : T0H)) ? 1'b1 : 1'b0;
    endfunction

    task automatic load_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        red = r; green = g; blue = b;
        load_sreg = 1'b1;
        step();
        load_sreg = 1'b0;
    endtask

    // Hold transmit for n cycles, recording dout, pixel_done and busy.
    task automatic shift_capture(input int n, input bit mid_load);
        done_cnt = 0; done_pos = -1; busy_bad = 0;
        transmit_pixel = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (mid_load && k == 150) begin
                red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
                load_sreg = 1'b1;
            end else begin
                load_sreg = 1'b0;
            end
            step();
            wave[k] = dout;
            if (pixel_done) begin
                done_cnt++;
                done_pos = k;
            end
            if (busy !== ((k < NCYC - 1) ? 1'b1 : 1'b0)) busy_bad++;
        end
        load_sreg = 1'b0;
    endtask

    task automatic check_wave(input logic [23:0] grb, input int n, input string name);
        int mism, first;
        mism = 0; first = -1;
        for (int k = 0; k < n; k++) begin
            if (wave[k] !== model_level(grb, k)) begin
                if (first < 0) first = k;
                mism++;
            end
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL %s waveform: %0d wrong cycles (first at %0d, got %b expected %b), pixel %h",
                     name, mism, first, wave[first], model_level(grb, first), grb);
        end
    endtask

    // Decode bits by measuring high time, and require every period to start high and end low.
    task automatic check_decode(input logic [23:0] want, input string name);
        logic [23:0] got;
        int          bad_period, highs;
        bad_period = 0;
        for (int b = 0; b < BPP; b++) begin
            highs = 0;
            for (int p = 0; p < CPB; p++) if (wave[b * CPB + p] === 1'b1) highs++;
            got[BPP - 1 - b] = (highs == T1H);
            if (wave[b * CPB] !== 1'b1 || wave[b * CPB + CPB - 1] !== 1'b0) bad_period++;
            if (highs != T0H && highs != T1H) bad_period++;
        end
        checks++;
        if (got !== want || bad_period != 0) begin
            errors++;
            $display("FAIL %s decode: got %h (%0d bad periods), expected %h", name, got,
                     bad_period, want);
        end
    endtask

    task automatic check_done_full(input string name);
        checks++;
        if (done_cnt != 1 || done_pos != NCYC - 1 || busy_bad != 0) begin
            errors++;
            $display("FAIL %s pixel_done/busy: %0d pulses at %0d, busy errors %0d, expected 1 at %0d",
                     name, done_cnt, done_pos, busy_bad, NCYC - 1);
        end
    endtask

    // Drop transmit after a full pixel; the drain edge must leave the line low and idle.
    task automatic drain_and_check(input string name);
        transmit_pixel = 1'b0;
        step();
        checks++;
        if (dout !== 1'b0 || busy !== 1'b0 || pixel_done !== 1'b0) begin
            errors++;
            $display("FAIL %s drain: dout=%b busy=%b pixel_done=%b, expected 0 0 0", name, dout,
                     busy, pixel_done);
        end
    endtask

    task automatic run_full_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                  input bit mid_load, input string name);
        logic [23:0] grb;
        grb = {g, r, b};
        load_pixel(r, g, b);
        shift_capture(NCYC, mid_load);
        check_wave(grb, NCYC, name);
        check_done_full(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({dout, busy, pixel_done, err_underrun, err_abort} !== 5'b0) begin
            errors++;
            $display("FAIL reset outputs: got %b, expected 00000",
                     {dout, busy, pixel_done, err_underrun, err_abort});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fixed_patterns();
        run_full_pixel(8'h00, 8'hFF, 8'h00, 1'b0, "green");
        check_decode(24'hFF0000, "green");
        drain_and_check("green");
        run_full_pixel(8'hA5, 8'h3C, 8'h81, 1'b0, "a5_3c_81");
        check_decode(24'h3CA581, "a5_3c_81");
        drain_and_check("a5_3c_81");
    endtask

    // Random pixels; odd ones also pulse load_sreg mid-shift, which must be ignored.
    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_full_pixel(8'($urandom), 8'($urandom), 8'($urandom), (i % 2) == 1, "random");
            drain_and_check("random");
        end
        checks++;
        if (err_abort !== 1'b0 || err_underrun !== 1'b0) begin
            errors++;
            $display("FAIL random flags: underrun=%b abort=%b, expected 0 0", err_underrun,
                     err_abort);
        end
    endtask

    // A load coinciding with transmit wins; shifting then uses the newer pixel.
    task automatic test_load_priority();
        logic [7:0] r2, g2, b2;
        r2 = 8'($urandom); g2 = 8'($urandom); b2 = 8'($urandom);
        load_pixel(8'($urandom), 8'($urandom), 8'($urandom));
        red = r2; green = g2; blue = b2;
        load_sreg = 1'b1;
        transmit_pixel = 1'b1;
        step();
        load_sreg = 1'b0;
        checks++;
        if (busy !== 1'b0 || dout !== 1'b0) begin
            errors++;
            $display("FAIL load_priority: busy=%b dout=%b, expected 0 0", busy, dout);
        end
        shift_capture(NCYC, 1'b0);
        check_wave({g2, r2, b2}, NCYC, "load_priority");
        drain_and_check("load_priority");
    endtask

    task automatic test_underrun();
        int highs;
        highs = 0;
        transmit_pixel = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (dout !== 1'b0 || busy !== 1'b0) highs++;
        end
        checks++;
        if (err_underrun !== 1'b1 || highs != 0) begin
            errors++;
            $display("FAIL underrun set: err_underrun=%b, %0d active cycles, expected 1 and 0",
                     err_underrun, highs);
        end
        transmit_pixel = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err_underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun clear: got %b, expected 0", err_underrun);
        end
        transmit_pixel = 1'b1;
        err_clr = 1'b1;
        step();
        transmit_pixel = 1'b0;
        err_clr = 1'b0;
        checks++;
        if (err_underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun set_wins: got %b, expected 1", err_underrun);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_abort();
        logic [7:0] r, g, b;
        int         late;
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        load_pixel(r, g, b);
        shift_capture(100, 1'b0);
        check_wave({g, r, b}, 100, "abort_prefix");
        transmit_pixel = 1'b0;
        step();
        checks++;
        if (dout !== 1'b0 || err_abort !== 1'b1 || busy !== 1'b0 || pixel_done !== 1'b0 ||
            done_cnt != 0) begin
            errors++;
            $display("FAIL abort: dout=%b err_abort=%b busy=%b pixel_done=%b, expected 0 1 0 0",
                     dout, err_abort, busy, pixel_done);
        end
        late = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (pixel_done !== 1'b0 || dout !== 1'b0) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL abort quiet: %0d active cycles after abort, expected 0", late);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort clear: got %b, expected 0", err_abort);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r, g, b;
        int         gap, total_done;
        run_full_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, "b2b_first");
        total_done = done_cnt;
        gap = 0;
        transmit_pixel = 1'b0;
        step();
        if (dout === 1'b0) gap++;
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        load_pixel(r, g, b);
        if (dout === 1'b0) gap++;
        shift_capture(NCYC, 1'b0);
        total_done += done_cnt;
        check_wave({g, r, b}, NCYC, "b2b_second");
        checks++;
        if (gap != 2 || total_done != 2) begin
            errors++;
            $display("FAIL back_to_back: gap %0d cycles, %0d pixel_done pulses, expected 2 and 2",
                     gap, total_done);
        end
        drain_and_check("b2b_second");
    endtask

    // Reset lands at cycle 7 of bit 3 with err_underrun set beforehand.
    task automatic test_async_reset();
        logic [7:0] r, g, b;
        transmit_pixel = 1'b1;
        step();
        transmit_pixel = 1'b0;
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        load_pixel(r, g, b);
        shift_capture(3 * CPB + 7 + 1, 1'b0);
        check_wave({g, r, b}, 3 * CPB + 7 + 1, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, busy, pixel_done, err_underrun, err_abort} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got %b, expected 00000",
                     {dout, busy, pixel_done, err_underrun, err_abort});
        end
        transmit_pixel = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        transmit_pixel = 1'b1;
        step();
        transmit_pixel = 1'b0;
        checks++;
        if (err_underrun !== 1'b1 || dout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset underrun: err_underrun=%b dout=%b busy=%b, expected 1 0 0",
                     err_underrun, dout, busy);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_patterns();
        test_random();
        test_load_priority();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_pixel_serializer.md
Name: ws2812_pixel_serializer

Overview:
- Downstream stage of the display controller. It takes the controller's load_sreg and transmit_pixel strobes plus the 24-bit colour for the current pixel, and drives the single-wire WS2812 LED data line.
- Latches {G,R,B} into a shift register and emits 24 bits MSB-first.
- Each bit occupies CYCLES_PER_BIT clocks, with high time T0H_CYCLES or T1H_CYCLES.
- Reports per-pixel completion and sticky protocol errors.

Parameters:
- CYCLES_PER_BIT, 15, clocks per encoded bit (1.25 us at 12 MHz).
- T0H_CYCLES, 5, high clocks for a '0' bit (must be 1..CYCLES_PER_BIT-1).
- T1H_CYCLES, 10, high clocks for a '1' bit (must be T0H_CYCLES+1..CYCLES_PER_BIT-1).
- BITS_PER_PIXEL, 24, bits shifted per load.

Ports:
- clk  in  1  system clock, 12 MHz; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load_sreg  in  1  one-cycle strobe: capture red/green/blue.
- transmit_pixel  in  1  level, held high for BITS_PER_PIXEL*CYCLES_PER_BIT cycles.
- red  in  8  pixel red channel.
- green  in  8  pixel green channel.
- blue  in  8  pixel blue channel.
- err_clr  in  1  clears error flags.
- dout  out  1  registered WS2812 data line.
- busy  out  1  high while in SHIFTING.
- pixel_done  out  1  one-cycle pulse after the last bit's final cycle.
- err_underrun  out  1  sticky: transmit started with no loaded pixel.
- err_abort  out  1  sticky: transmit_pixel dropped before 24 bits completed.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sreg=0, bit_cycle=0, bit_cnt=0, dout=0, busy=0, pixel_done=0, err_underrun=0, err_abort=0.
- States:
  - IDLE: no valid pixel.
  - LOADED: pixel captured, awaiting transmit.
  - SHIFTING: emitting bits.
  - DRAIN: 24 bits sent, waiting for transmit_pixel to fall.
- IDLE or LOADED with load_sreg=1: sreg <= {green,red,blue}; go to LOADED. If transmit_pixel is also high that cycle, the load wins and transmit is ignored for that cycle.
- LOADED with transmit_pixel=1 (and load_sreg=0): go to SHIFTING with bit_cycle=0, bit_cnt=0. dout <= 1 on this same edge, so dout lags transmit_pixel by exactly one cycle.
- IDLE with transmit_pixel=1: set err_underrun, stay IDLE, dout stays 0.
- SHIFTING, each cycle:
  - dout <= (bit_cycle < (sreg[23] ? T1H_CYCLES : T0H_CYCLES)).
  - bit_cycle increments.
  - At bit_cycle==CYCLES_PER_BIT-1: bit_cycle<=0, sreg<=sreg<<1, bit_cnt++.
  - At the last cycle of bit 23: pixel_done<=1 (pulse), go to DRAIN.
- The waveform is therefore continuous across bit boundaries: no gap cycles.
- SHIFTING with transmit_pixel=0: go to IDLE, dout<=0, set err_abort, sreg contents discarded.
- SHIFTING with load_sreg=1: load ignored, no error.
- DRAIN: dout=0. Leave when transmit_pixel=0, going to LOADED if load_sreg is high that cycle, otherwise IDLE. The controller drops transmit_pixel on the cycle after the final bit, so DRAIN normally lasts one cycle.
- Frame reset/latch (>50 us low) is produced upstream by the controller's idle period. This block only guarantees dout=0 outside SHIFTING.
- err_clr=1: clears both error flags. If an error event occurs in the same cycle, the set wins.
- Widths:
  - bit_cycle: $clog2(CYCLES_PER_BIT) bits; wraps explicitly, never by overflow.
  - bit_cnt: $clog2(BITS_PER_PIXEL+1) bits.
- busy = (state==SHIFTING), combinational from the state register.

Decomposition:
- Package ws2812_pkg:
  - state enum {IDLE, LOADED, SHIFTING, DRAIN}.
  - default timing constants (CYCLES_PER_BIT, T0H/T1H, BITS_PER_PIXEL).
  - function pack_grb(r,g,b) returning 24 bits.
- Sub-module ws2812_bit_encoder:
  - bit_cycle counter and high-time compare.
  - Inputs: enable, bit_value.
  - Outputs: level, bit_end.
- The top module holds the FSM, shift register, bit counter and error flags.

Test Plan:
- Load r=0x00, g=0xFF, b=0x00, then hold transmit 360 cycles -> dout: 8 bits of 10-high/5-low, then 16 bits of 5-high/10-low. pixel_done pulses on cycle 360 after transmit rises (one cycle of latency).
- Load r=0xA5, g=0x3C, b=0x81 -> decoded bitstream 0x3CA581 MSB-first; every bit period exactly 15 cycles; dout=0 after the last bit.
- transmit_pixel with no prior load after reset -> err_underrun=1, dout stays 0. err_clr then clears it.
- transmit_pixel dropped at cycle 100 -> next cycle dout=0, err_abort=1, busy=0, no pixel_done.
- Back-to-back pixels driven by the controller sequence (load, transmit 360, load, transmit 360) -> two pixel_done pulses, 24+24 correctly encoded bits, dout low for exactly 2 cycles between pixels.
- rst_n asserted mid-bit (cycle 7 of bit 3) -> dout, busy and flags are 0 immediately (asynchronous). After release, transmit without a load sets err_underrun.
